// File: rtl/pong_state_engine_if.sv
// rtl/pong_state_engine_if.sv - game coordinate bundle from pong_state_engine to vga_controller
interface pong_state_engine_if;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [8:0] paddle_left_y;
    logic [8:0] paddle_right_y;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic       frame_tick;

    modport master (
        output ball_x, ball_y, paddle_left_y, paddle_right_y,
        output score_left, score_right, game_over, frame_tick
    );

    modport slave (
        input ball_x, ball_y, paddle_left_y, paddle_right_y,
        input score_left, score_right, game_over, frame_tick
    );
endinterface

// File: rtl/pong_state_engine.sv
// rtl/pong_state_engine.sv - per-frame pong game state engine (PONG_AI_RIGHT_EN: right paddle follows the ball)
module pong_state_engine #(
    parameter int BALL_VX      = 2,
    parameter int BALL_VY      = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic                iVGA_CLK,
    input  logic                iRST_n,
    input  logic                iVS,
    input  logic                btn_l_up,
    input  logic                btn_l_dn,
    input  logic                btn_r_up,
    input  logic                btn_r_dn,
    input  logic                btn_start,
    pong_state_engine_if.master game
);
    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

    localparam logic signed [10:0] CX      = 11'sd315;
    localparam logic signed [10:0] CY      = 11'sd235;
    localparam logic signed [10:0] PAD0    = 11'sd220;
    localparam logic signed [10:0] PAD_MAX = 11'sd440;
    localparam logic signed [10:0] Y_MAX   = 11'sd470;
    localparam logic signed [10:0] X_MAX   = 11'sd630;
    localparam logic signed [10:0] L_EDGE  = 11'sd30;
    localparam logic signed [10:0] R_EDGE  = 11'sd600;
    localparam logic signed [10:0] BALL_H  = 11'sd10;
    localparam logic signed [10:0] PAD_H   = 11'sd40;
    localparam logic signed [10:0] VX      = 11'(BALL_VX);
    localparam logic signed [10:0] VY      = 11'(BALL_VY);
    localparam logic signed [10:0] PSPD    = 11'(PADDLE_SPEED);
    localparam logic [3:0]         WIN     = 4'(WIN_SCORE);
    localparam logic [8:0]         SERVE_N = 9'(SERVE_FRAMES);

    logic       vs_s1, vs_s2, vs_d, tick;
    logic [4:0] btn_s1, btn_s2;
    logic       start_d, start_rise;
    logic       r_up, r_dn;

    state_t            state_q, state_n;
    logic signed [10:0] bx_q, by_q, pl_q, pr_q;
    logic signed [10:0] bx_n, by_n, pl_n, pr_n;
    logic              vx_neg_q, vy_neg_q, vx_neg_n, vy_neg_n;
    logic [3:0]        sl_q, sr_q, sl_n, sr_n;
    logic [7:0]        cnt_q, cnt_n;
    logic              ftick_q;

    logic signed [10:0] vx, vy, nx, ny;
    logic              hit_l, hit_r;

    // Synchronise raw inputs, detect the frame-sync fall and the restart button press
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_d    <= 1'b1;
            tick    <= 1'b0;
            btn_s1  <= '0;
            btn_s2  <= '0;
            start_d <= 1'b0;
        end else begin
            vs_s1   <= iVS;
            vs_s2   <= vs_s1;
            vs_d    <= vs_s2;
            tick    <= vs_d & ~vs_s2;
            btn_s1  <= {btn_start, btn_r_dn, btn_r_up, btn_l_dn, btn_l_up};
            btn_s2  <= btn_s1;
            start_d <= btn_s2[4];
        end
    end

    assign start_rise = btn_s2[4] & ~start_d;

`ifdef PONG_AI_RIGHT_EN
    logic signed [10:0] ai_diff;
    logic               unused_r_btns;
    assign unused_r_btns = ^btn_s2[3:2];
    assign ai_diff = (by_q - 11'sd15) - pr_q;
    assign r_up    = ai_diff < -PSPD;
    assign r_dn    = ai_diff > PSPD;
`else
    assign r_up = btn_s2[2];
    assign r_dn = btn_s2[3];
`endif

    function automatic logic signed [10:0] paddle_step(input logic signed [10:0] y,
                                                       input logic up, input logic dn);
        logic signed [10:0] t;
        t = y;
        if (up && !dn) begin
            t = y - PSPD;
            if (t < 11'sd0) t = 11'sd0;
        end else if (dn && !up) begin
            t = y + PSPD;
            if (t > PAD_MAX) t = PAD_MAX;
        end
        return t;
    endfunction

    assign vx    = vx_neg_q ? -VX : VX;
    assign vy    = vy_neg_q ? -VY : VY;
    assign nx    = bx_q + vx;
    assign ny    = by_q + vy;
    assign hit_l = vx_neg_q && (bx_q >= L_EDGE) && (nx < L_EDGE) &&
                   (by_q + BALL_H > pl_q) && (by_q < pl_q + PAD_H);
    assign hit_r = !vx_neg_q && (bx_q <= R_EDGE) && (nx > R_EDGE) &&
                   (by_q + BALL_H > pr_q) && (by_q < pr_q + PAD_H);

    // Game state register; restart from OVER is immediate, everything else waits for a frame tick
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= S_SERVE;
            bx_q     <= CX;
            by_q     <= CY;
            pl_q     <= PAD0;
            pr_q     <= PAD0;
            vx_neg_q <= 1'b0;
            vy_neg_q <= 1'b0;
            sl_q     <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            ftick_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            bx_q     <= bx_n;
            by_q     <= by_n;
            pl_q     <= pl_n;
            pr_q     <= pr_n;
            vx_neg_q <= vx_neg_n;
            vy_neg_q <= vy_neg_n;
            sl_q     <= sl_n;
            sr_q     <= sr_n;
            cnt_q    <= cnt_n;
            ftick_q  <= tick;
        end
    end

    // Next-state and next-position logic for serve, play, point and game over
    always_comb begin
        state_n  = state_q;
        bx_n     = bx_q;
        by_n     = by_q;
        pl_n     = pl_q;
        pr_n     = pr_q;
        vx_neg_n = vx_neg_q;
        vy_neg_n = vy_neg_q;
        sl_n     = sl_q;
        sr_n     = sr_q;
        cnt_n    = cnt_q;
        if (state_q == S_OVER) begin
            bx_n = CX;
            by_n = CY;
            if (start_rise) begin
                sl_n    = '0;
                sr_n    = '0;
                cnt_n   = '0;
                state_n = S_SERVE;
            end
        end else if (tick) begin
            pl_n = paddle_step(pl_q, btn_s2[0], btn_s2[1]);
            pr_n = paddle_step(pr_q, r_up, r_dn);
            case (state_q)
                S_SERVE: begin
                    bx_n = CX;
                    by_n = CY;
                    if ({1'b0, cnt_q} + 9'd1 == SERVE_N) begin
                        cnt_n   = '0;
                        state_n = S_PLAY;
                    end else begin
                        cnt_n = cnt_q + 8'd1;
                    end
                end
                S_PLAY: begin
                    if (ny <= 11'sd0) begin
                        by_n     = 11'sd0;
                        vy_neg_n = 1'b0;
                    end else if (ny >= Y_MAX) begin
                        by_n     = Y_MAX;
                        vy_neg_n = 1'b1;
                    end else begin
                        by_n = ny;
                    end
                    if (hit_l) begin
                        bx_n     = L_EDGE;
                        vx_neg_n = 1'b0;
                    end else if (hit_r) begin
                        bx_n     = R_EDGE;
                        vx_neg_n = 1'b1;
                    end else if (nx <= 11'sd0) begin
                        sr_n     = (sr_q >= WIN) ? sr_q : sr_q + 4'd1;
                        vx_neg_n = 1'b1;
                        state_n  = S_POINT;
                    end else if (nx >= X_MAX) begin
                        sl_n     = (sl_q >= WIN) ? sl_q : sl_q + 4'd1;
                        vx_neg_n = 1'b0;
                        state_n  = S_POINT;
                    end else begin
                        bx_n = nx;
                    end
                end
                S_POINT: begin
                    bx_n = CX;
                    by_n = CY;
                    // serve direction points away from the player who just scored
                    if ((vx_neg_q ? sr_q : sl_q) == WIN) state_n = S_OVER;
                    else                                  state_n = S_SERVE;
                end
                default: ;
            endcase
        end
    end

    assign game.ball_x         = bx_q[9:0];
    assign game.ball_y         = by_q[8:0];
    assign game.paddle_left_y  = pl_q[8:0];
    assign game.paddle_right_y = pr_q[8:0];
    assign game.score_left     = sl_q;
    assign game.score_right    = sr_q;
    assign game.game_over      = (state_q == S_OVER);
    assign game.frame_tick     = ftick_q;
endmodule

// File: tb/tb_pong_state_engine.sv
// tb/tb_pong_state_engine.sv - randomized self-checking bench for pong_state_engine against a frame-level game model
module tb_pong_state_engine;
    localparam int SERVE = 0, PLAY = 1, POINT = 2, OVER = 3;

    logic iVGA_CLK  = 1'b0;
    logic iRST_n    = 1'b0;
    logic iVS       = 1'b1;
    logic btn_l_up  = 1'b0;
    logic btn_l_dn  = 1'b0;
    logic btn_r_up  = 1'b0;
    logic btn_r_dn  = 1'b0;
    logic btn_start = 1'b0;

    pong_state_engine_if game_if();

    pong_state_engine dut (
        .iVGA_CLK  (iVGA_CLK),
        .iRST_n    (iRST_n),
        .iVS       (iVS),
        .btn_l_up  (btn_l_up),
        .btn_l_dn  (btn_l_dn),
        .btn_r_up  (btn_r_up),
        .btn_r_dn  (btn_r_dn),
        .btn_start (btn_start),
        .game      (game_if)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Frame-level model of the game
    int m_bx, m_by, m_pl, m_pr, m_vx, m_vy, m_sl, m_sr, m_cnt, m_phase;
    bit m_left_scored;

    task automatic model_reset();
        m_bx = 315; m_by = 235; m_pl = 220; m_pr = 220;
        m_vx = 2; m_vy = 2; m_sl = 0; m_sr = 0; m_cnt = 0; m_phase = SERVE;
        m_left_scored = 1'b0;
    endtask

    function automatic int move_paddle(input int p, input bit u, input bit d);
        if (u && !d) return (p - 4 < 0) ? 0 : p - 4;
        if (d && !u) return (p + 4 > 440) ? 440 : p + 4;
        return p;
    endfunction

    task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd);
        int nx, ny, old_y;
        bit hl, hr;
        if (m_phase == OVER) return;
`ifdef PONG_AI_RIGHT_EN
        ru = ((m_by - 15) - m_pr) < -4;
        rd = ((m_by - 15) - m_pr) > 4;
`endif
        old_y = m_by;
        if (m_phase == SERVE) begin
            m_cnt++;
            if (m_cnt == 60) begin m_cnt = 0; m_phase = PLAY; end
        end else if (m_phase == PLAY) begin
            nx = m_bx + m_vx;
            ny = m_by + m_vy;
            if (ny <= 0)        begin m_by = 0;   m_vy = 2;  end
            else if (ny >= 470) begin m_by = 470; m_vy = -2; end
            else                m_by = ny;
            hl = (m_vx < 0) && (m_bx >= 30) && (nx < 30) && (old_y + 10 > m_pl) && (old_y < m_pl + 40);
            hr = (m_vx > 0) && (m_bx <= 600) && (nx > 600) && (old_y + 10 > m_pr) && (old_y < m_pr + 40);
            if (hl)             begin m_bx = 30;  m_vx = 2;  end
            else if (hr)        begin m_bx = 600; m_vx = -2; end
            else if (nx <= 0)   begin m_sr = (m_sr < 7) ? m_sr + 1 : 7; m_vx = -2; m_left_scored = 1'b0; m_phase = POINT; end
            else if (nx >= 630) begin m_sl = (m_sl < 7) ? m_sl + 1 : 7; m_vx = 2;  m_left_scored = 1'b1; m_phase = POINT; end
            else                m_bx = nx;
        end else begin
            m_bx = 315; m_by = 235;
            m_phase = (((m_left_scored ? m_sl : m_sr)) == 7) ? OVER : SERVE;
        end
        m_pl = move_paddle(m_pl, lu, ld);
        m_pr = move_paddle(m_pr, ru, rd);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".ball_x"},    int'(game_if.ball_x),         m_bx);
        check({tag, ".ball_y"},    int'(game_if.ball_y),         m_by);
        check({tag, ".pad_l"},     int'(game_if.paddle_left_y),  m_pl);
        check({tag, ".pad_r"},     int'(game_if.paddle_right_y), m_pr);
        check({tag, ".score_l"},   int'(game_if.score_left),     m_sl);
        check({tag, ".score_r"},   int'(game_if.score_right),    m_sr);
        check({tag, ".game_over"}, int'(game_if.game_over),      (m_phase == OVER) ? 1 : 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ball_x"},     int'(game_if.ball_x),         315);
        check({tag, ".ball_y"},     int'(game_if.ball_y),         235);
        check({tag, ".pad_l"},      int'(game_if.paddle_left_y),  220);
        check({tag, ".pad_r"},      int'(game_if.paddle_right_y), 220);
        check({tag, ".score_l"},    int'(game_if.score_left),     0);
        check({tag, ".score_r"},    int'(game_if.score_right),    0);
        check({tag, ".game_over"},  int'(game_if.game_over),      0);
        check({tag, ".frame_tick"}, int'(game_if.frame_tick),     0);
    endtask

    // One video frame: buttons set while iVS is high, then iVS falls at edge N
    task automatic do_frame(input bit lu, input bit ld, input bit ru, input bit rd);
        int h;
        h = $urandom_range(5, 9);
        @(negedge iVGA_CLK);
        btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
        iVS = 1'b1;
        repeat (h - 1) @(negedge iVGA_CLK);
        check("tick_idle", int'(game_if.frame_tick), 0);
        iVS = 1'b0;
        @(posedge iVGA_CLK);
        @(posedge iVGA_CLK); #1;
        check("tick_n1", int'(game_if.frame_tick), 0);
        @(posedge iVGA_CLK); #1;
        check("tick_n2", int'(game_if.frame_tick), 0);
        check("held_x_n2", int'(game_if.ball_x), m_bx);
        @(posedge iVGA_CLK); #1;
        check("tick_n3", int'(game_if.frame_tick), 1);
        model_tick(lu, ld, ru, rd);
        compare_all("frame");
        @(posedge iVGA_CLK); #1;
        check("tick_n4", int'(game_if.frame_tick), 0);
        @(negedge iVGA_CLK);
        iVS = 1'b1;
    endtask

    task automatic press_start();
        @(negedge iVGA_CLK);
        btn_start = 1'b1;
        repeat (4) @(negedge iVGA_CLK);
        btn_start = 1'b0;
        repeat (3) @(negedge iVGA_CLK);
        if (m_phase == OVER) begin
            m_sl = 0; m_sr = 0; m_cnt = 0; m_phase = SERVE;
        end
        compare_all("start");
    endtask

    task automatic track(input int p, input int by, output bit u, output bit d);
        u = p > by - 15;
        d = p < by - 15;
    endtask

    task automatic apply_reset_midcycle(input string tag);
        @(posedge iVGA_CLK); #3;
        iRST_n = 1'b0;
        #1;
        check_reset_vals(tag);
        model_reset();
        repeat (2) @(negedge iVGA_CLK);
        iRST_n = 1'b1;
    endtask

    initial begin
        bit lu, ld, ru, rd;
        int n;
        model_reset();
        repeat (3) @(negedge iVGA_CLK);
        check_reset_vals("reset");
        iRST_n = 1'b1;

        // Three idle serve frames
        for (int f = 0; f < 3; f++) begin
            do_frame(1'b0, 1'b0, 1'b0, 1'b0);
            check("idle_ball_x", int'(game_if.ball_x), 315);
        end

        // Left up held through the rest of the serve: paddle floors at 0
        for (int f = 0; f < 57; f++) do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        check("pad_l_floor", int'(game_if.paddle_left_y), 0);

        // First play tick with both left buttons held
        do_frame(1'b1, 1'b1, 1'b0, 1'b0);
        check("first_play_x", int'(game_if.ball_x), 317);
        check("first_play_y", int'(game_if.ball_y), 237);
        check("both_btn_pad", int'(game_if.paddle_left_y), 0);
        do_frame(1'b1, 1'b1, 1'b0, 1'b0);

        // Randomized rally with tracking paddles, button noise and stray start presses
        for (int f = 0; f < 600; f++) begin
            track(m_pl, m_by, lu, ld);
            track(m_pr, m_by, ru, rd);
            if ($urandom_range(0, 9) < 3) begin lu = 1'($urandom); ld = 1'($urandom); end
            if ($urandom_range(0, 9) < 3) begin ru = 1'($urandom); rd = 1'($urandom); end
            do_frame(lu, ld, ru, rd);
            if ($urandom_range(0, 49) == 0) press_start();
        end

        // Asynchronous reset in the middle of a clock cycle
        apply_reset_midcycle("async_rst");

        // Left tracks the ball, right parked at the top: left wins
        n = 0;
        while (m_phase != OVER && n < 3000) begin
            track(m_pl, m_by, lu, ld);
            do_frame(lu, ld, 1'b1, 1'b0);
            n++;
        end
        check("game_over_set", int'(game_if.game_over), 1);
        check("win_score_l", int'(game_if.score_left), 7);
        for (int f = 0; f < 4; f++)
            do_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        check("over_frozen_x", int'(game_if.ball_x), 315);
        press_start();
        check("restart_score_l", int'(game_if.score_left), 0);
        check("restart_over", int'(game_if.game_over), 0);
        for (int f = 0; f < 3; f++) do_frame(1'b0, 1'b1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/pong_state_engine.md
Name: pong_state_engine

Overview:
- Produces the game coordinates consumed by vga_controller: ball_x, ball_y, paddle_left_y, paddle_right_y.
- Advances the game once per video frame, on the falling edge of the frame sync.
- Handles ball motion, wall bounces, paddle hits, misses, scoring, serve delay and game over.
- Sits between the player button inputs and vga_controller's coordinate inputs.
- Screen is 640x480. Ball is 10x10. Paddles are 10x40, at x 20..29 (left) and x 610..619 (right).

Parameters:
- BALL_VX, 2, horizontal ball speed in pixels/frame (1..9).
- BALL_VY, 2, vertical ball speed in pixels/frame (1..9).
- PADDLE_SPEED, 4, paddle speed in pixels/frame (1..20).
- WIN_SCORE, 7, score that ends the game (1..15).
- SERVE_FRAMES, 60, frames the ball is held at centre before each serve (1..255).

Ports:
- iVGA_CLK  in  1  pixel clock; all logic on its rising edge.
- iRST_n  in  1  asynchronous active-low reset.
- iVS  in  1  active-low vertical sync from video_sync_generator.
- btn_l_up, btn_l_dn, btn_r_up, btn_r_dn  in  1 each  raw active-high paddle buttons.
- btn_start  in  1  raw active-high restart button.
- ball_x  out  10  ball top-left x.
- ball_y  out  9  ball top-left y.
- paddle_left_y  out  9  left paddle top y.
- paddle_right_y  out  9  right paddle top y.
- score_left  out  4  left player score.
- score_right  out  4  right player score.
- game_over  out  1  high while in the OVER state.
- frame_tick  out  1  one-cycle pulse in the cycle the outputs take new values.

Behaviour:
- Reset (async, iRST_n=0):
  - ball_x=315, ball_y=235, both paddles=220, scores=0.
  - game_over=0, frame_tick=0, state=SERVE, serve counter=0.
  - Velocity: vx=+BALL_VX, vy=+BALL_VY.
  - A reset mid-game restores all of the above immediately.
- Input synchronisation: iVS and all buttons pass through 2-flop synchronisers.
- Frame tick timing:
  - Internal tick = synchronised iVS goes 1 to 0.
  - If iVS is sampled low at edge N (high at N-1), the outputs and frame_tick change at edge N+3.
  - Outputs are otherwise held constant for the whole frame.
  - Exactly one update per frame.
- All position arithmetic is 11-bit signed internally. Outputs are truncated only after clamping, so they are never negative and never wrap.
- Paddles (updated each tick in SERVE and PLAY; frozen in OVER):
  - Up only: y -= PADDLE_SPEED, floored at 0.
  - Down only: y += PADDLE_SPEED, capped at 440.
  - Both or neither pressed: no move.
- States:
  - SERVE:
    - Ball held at (315, 235).
    - Counter increments each tick. When it reaches SERVE_FRAMES, it clears and the state goes to PLAY.
    - The ball first moves on the following tick.
  - PLAY (each tick): nx = ball_x+vx, ny = ball_y+vy. Then apply the rules below.
    - Y walls:
      - ny <= 0: y=0, vy=+BALL_VY.
      - ny >= 470: y=470, vy=-BALL_VY.
      - Otherwise y=ny.
    - Left paddle hit: all of vx<0, ball_x>=30, nx<30, ball_y+10 > paddle_left_y, ball_y < paddle_left_y+40. Then x=30, vx=+BALL_VX.
    - Right paddle hit: all of vx>0, ball_x<=600, nx>600, ball_y+10 > paddle_right_y, ball_y < paddle_right_y+40. Then x=600, vx=-BALL_VX.
    - Paddle overlap uses the pre-update ball_y and paddle values.
    - Left miss: nx <= 0 with no hit. Right player scores, next serve vx=-BALL_VX, go to POINT.
    - Right miss: nx >= 630 with no hit. Left player scores, next serve vx=+BALL_VX, go to POINT.
    - Otherwise x=nx.
    - X and Y are resolved independently in the same tick, so a corner gives both a bounce and a hit.
  - POINT (one tick):
    - Ball recentred.
    - If the scoring player's score equals WIN_SCORE, go to OVER; else go to SERVE.
  - OVER:
    - game_over=1, ball at centre, scores held.
    - A rising edge of synchronised btn_start clears the scores and goes to SERVE.
    - A restart takes effect immediately, not on a frame tick.
- Scores saturate at WIN_SCORE and never exceed 15.

Optional Feature:
- Macro: PONG_AI_RIGHT_EN.
- Defined: btn_r_up and btn_r_dn are ignored. Each tick, the right paddle moves by PADDLE_SPEED toward a target of ball_y-15, with the same clamping. It does not move if within PADDLE_SPEED of the target.
- Undefined: the right paddle is driven by buttons exactly as the left paddle is.

Test Plan:
- Reset, then 3 frames with no buttons: ball=(315,235), paddles=220, scores=0, frame_tick exactly 3 pulses, each at edge N+3 after the iVS fall.
- Hold btn_l_up for 60 frames: paddle_left_y reaches 0 after 55 frames and stays 0. Both left buttons held: no change.
- After 60 serve frames: first PLAY tick gives ball=(317,237). The ball reaches y=470 and the next tick has vy negative.
- Right paddle parked at 220, ball travelling right: ball reaches x=600 then moves to x=598. Paddle parked at 0: ball passes, score_left=1, then 60 frames at centre.
- Let the left player score 7 times: game_over=1, outputs frozen. Pulse btn_start: scores=0, state SERVE.
- Assert iRST_n low during PLAY mid-cycle: all outputs return to reset values before the next clock edge.
